// File: rtl/rob_multiport_if.sv
// Bus bundle for rob_multiport: issue allocation, NUM_WB writeback channels,
// in-order commit handshake and occupancy status.
interface rob_multiport_if #(
  parameter int IDX_W  = 3,
  parameter int NUM_WB = 3,
  parameter int DATA_W = 32
);
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [IDX_W-1:0]         alloc_idx;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*IDX_W-1:0]  wb_idx;
  logic [NUM_WB-1:0]        wb_we;
  logic [NUM_WB*5-1:0]      wb_rd;
  logic [NUM_WB*DATA_W-1:0] wb_val;
  logic [NUM_WB*DATA_W-1:0] wb_pc;
  logic [NUM_WB-1:0]        wb_ex;
  logic [NUM_WB-1:0]        wb_store;
  logic [NUM_WB*DATA_W-1:0] wb_addr;
  logic                     commit_valid;
  logic                     commit_ready;
  logic                     commit_we;
  logic [4:0]               commit_rd;
  logic [DATA_W-1:0]        commit_val;
  logic                     commit_store;
  logic [DATA_W-1:0]        commit_addr;
  logic                     commit_ex;
  logic [DATA_W-1:0]        commit_epc;
  logic                     flush;
  logic [IDX_W:0]           count;
  logic                     full;
  logic                     empty;

  modport master (
    output alloc_valid, wb_valid, wb_idx, wb_we, wb_rd, wb_val, wb_pc, wb_ex,
           wb_store, wb_addr, commit_ready,
    input  alloc_ready, alloc_idx, commit_valid, commit_we, commit_rd, commit_val,
           commit_store, commit_addr, commit_ex, commit_epc, flush, count, full, empty
  );

  modport slave (
    input  alloc_valid, wb_valid, wb_idx, wb_we, wb_rd, wb_val, wb_pc, wb_ex,
           wb_store, wb_addr, commit_ready,
    output alloc_ready, alloc_idx, commit_valid, commit_we, commit_rd, commit_val,
           commit_store, commit_addr, commit_ex, commit_epc, flush, count, full, empty
  );
endinterface

// File: rtl/rob_multiport.sv
// Reorder buffer: in-order allocation, out-of-order multi-channel writeback,
// in-order commit with whole-buffer flush on a faulting commit.
module rob_multiport_chk #(
  parameter int IDX_W  = 3,
  parameter int NUM_WB = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic [NUM_WB-1:0]       wb_valid,
  input logic [NUM_WB*IDX_W-1:0] wb_idx
);
  logic dup_s;

  // Flag any two live writeback channels aimed at the same entry
  always_comb begin
    dup_s = 1'b0;
    for (int j = 0; j < NUM_WB; j++) begin
      for (int k = j + 1; k < NUM_WB; k++) begin
        if (wb_valid[j] && wb_valid[k] &&
            (wb_idx[j*IDX_W +: IDX_W] == wb_idx[k*IDX_W +: IDX_W])) begin
          dup_s = 1'b1;
        end else begin
          dup_s = dup_s;
        end
      end
    end
  end

  a_no_dup_wb: assert property (@(posedge clk) disable iff (!rst_n) !dup_s);
endmodule

module rob_multiport #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int NUM_WB = 3,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  rob_multiport_if.slave bus
);
  localparam int             CH_W      = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam int             RD_W      = 5;
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE   = (IDX_W + 1)'(1);

  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              flush_q, flush_d;
  logic [DEPTH-1:0]  busy_q, busy_d, done_q, done_d;
  logic [DEPTH-1:0]  we_q, we_d, ex_q, ex_d, store_q, store_d;
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [RD_W-1:0]   rd_d   [DEPTH];
  logic [DATA_W-1:0] val_q  [DEPTH];
  logic [DATA_W-1:0] val_d  [DEPTH];
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] pc_d   [DEPTH];
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] addr_d [DEPTH];

  logic [DEPTH-1:0]  wb_hit_s;
  logic [CH_W-1:0]   wb_sel_s [DEPTH];
  logic              full_s, commit_valid_s, do_alloc_s, do_commit_s, do_flush_s;

  assign full_s         = (count_q == DEPTH_CNT);
  assign commit_valid_s = busy_q[head_q] & done_q[head_q];
  assign do_alloc_s     = bus.alloc_valid & ~full_s;
  assign do_commit_s    = commit_valid_s & bus.commit_ready;
  assign do_flush_s     = do_commit_s & ex_q[head_q];

  assign bus.alloc_ready  = ~full_s;
  assign bus.alloc_idx    = tail_q;
  assign bus.full         = full_s;
  assign bus.empty        = (count_q == '0);
  assign bus.count        = count_q;
  assign bus.flush        = flush_q;
  assign bus.commit_valid = commit_valid_s;
  assign bus.commit_we    = we_q[head_q];
  assign bus.commit_rd    = rd_q[head_q];
  assign bus.commit_val   = val_q[head_q];
  assign bus.commit_store = store_q[head_q];
  assign bus.commit_addr  = addr_q[head_q];
  assign bus.commit_ex    = ex_q[head_q];
  assign bus.commit_epc   = pc_q[head_q];

  // Per entry: which channel (lowest number wins) targets it this cycle
  always_comb begin
    wb_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wb_sel_s[i] = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (bus.wb_valid[k] && (bus.wb_idx[k*IDX_W +: IDX_W] == IDX_W'(i))) begin
          wb_hit_s[i] = 1'b1;
          wb_sel_s[i] = CH_W'(k);
        end else begin
          wb_hit_s[i] = wb_hit_s[i];
        end
      end
    end
  end

  // Next state: a faulting commit overrides everything else in its cycle
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    flush_d = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    we_d    = we_q;
    ex_d    = ex_q;
    store_d = store_q;
    rd_d    = rd_q;
    val_d   = val_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    if (do_flush_s) begin
      busy_d  = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      flush_d = 1'b1;
    end else begin
      // A writeback racing the commit of its own entry is dropped
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_hit_s[i] && busy_q[i] && !(do_commit_s && (head_q == IDX_W'(i)))) begin
          done_d[i]  = 1'b1;
          we_d[i]    = bus.wb_we[wb_sel_s[i]];
          ex_d[i]    = bus.wb_ex[wb_sel_s[i]];
          store_d[i] = bus.wb_store[wb_sel_s[i]];
          rd_d[i]    = bus.wb_rd[wb_sel_s[i]*RD_W +: RD_W];
          val_d[i]   = bus.wb_val[wb_sel_s[i]*DATA_W +: DATA_W];
          pc_d[i]    = bus.wb_pc[wb_sel_s[i]*DATA_W +: DATA_W];
          addr_d[i]  = bus.wb_addr[wb_sel_s[i]*DATA_W +: DATA_W];
        end else begin
          done_d[i] = done_q[i];
        end
      end
      if (do_commit_s) begin
        busy_d[head_q] = 1'b0;
        done_d[head_q] = 1'b0;
        head_d         = head_q + IDX_W'(1);
      end else begin
        head_d = head_q;
      end
      if (do_alloc_s) begin
        busy_d[tail_q] = 1'b1;
        done_d[tail_q] = 1'b0;
        tail_d         = tail_q + IDX_W'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({do_alloc_s, do_commit_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      busy_q  <= '0;
      done_q  <= '0;
      we_q    <= '0;
      ex_q    <= '0;
      store_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        val_q[i]  <= '0;
        pc_q[i]   <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      ex_q    <= ex_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  rob_multiport_chk #(.IDX_W(IDX_W), .NUM_WB(NUM_WB)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (bus.wb_valid),
    .wb_idx   (bus.wb_idx)
  );
endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: directed scenarios plus random traffic, all checked
// against a program-order queue model of the buffer.
module tb_rob_multiport;
  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int NUM_WB = 3;
  localparam int DATA_W = 32;

  typedef struct {
    bit                done;
    logic              we;
    logic [4:0]        rd;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] pc;
    logic              ex;
    logic              store;
    logic [DATA_W-1:0] addr;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Model: q[0] is the oldest in-flight instruction, sitting at slot m_head
  ent_t q[$];
  int   m_head  = 0;
  bit   m_flush = 1'b0;

  always #5 clk = ~clk;

  rob_multiport_if #(.IDX_W(IDX_W), .NUM_WB(NUM_WB), .DATA_W(DATA_W)) bus ();

  rob_multiport #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic int m_tail();
    return (m_head + q.size()) % DEPTH;
  endfunction

  function automatic bit m_cvalid();
    if (q.size() == 0) return 1'b0;
    return q[0].done;
  endfunction

  function automatic void m_reset();
    q.delete();
    m_head  = 0;
    m_flush = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus
  function automatic void mdl_clock();
    bit   cmt;
    bit   alc;
    int   pos;
    ent_t e;
    cmt = m_cvalid() && bus.commit_ready;
    if (cmt && q[0].ex) begin
      q.delete();
      m_head  = 0;
      m_flush = 1'b1;
      return;
    end
    m_flush = 1'b0;
    alc = bus.alloc_valid && (q.size() < DEPTH);
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (bus.wb_valid[k]) begin
        pos = (int'(bus.wb_idx[k*IDX_W +: IDX_W]) - m_head + DEPTH) % DEPTH;
        if (pos < q.size() && !(cmt && pos == 0)) begin
          q[pos].done  = 1'b1;
          q[pos].we    = bus.wb_we[k];
          q[pos].rd    = bus.wb_rd[k*5 +: 5];
          q[pos].val   = bus.wb_val[k*DATA_W +: DATA_W];
          q[pos].pc    = bus.wb_pc[k*DATA_W +: DATA_W];
          q[pos].ex    = bus.wb_ex[k];
          q[pos].store = bus.wb_store[k];
          q[pos].addr  = bus.wb_addr[k*DATA_W +: DATA_W];
        end
      end
    end
    if (cmt) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (alc) begin
      e.done = 1'b0; e.we = 1'b0; e.rd = '0; e.val = '0;
      e.pc = '0; e.ex = 1'b0; e.store = 1'b0; e.addr = '0;
      q.push_back(e);
    end
  endfunction

  task automatic idle();
    bus.alloc_valid  = 1'b0;
    bus.commit_ready = 1'b0;
    bus.wb_valid     = '0;
    bus.wb_idx       = '0;
    bus.wb_we        = '0;
    bus.wb_rd        = '0;
    bus.wb_val       = '0;
    bus.wb_pc        = '0;
    bus.wb_ex        = '0;
    bus.wb_store     = '0;
    bus.wb_addr      = '0;
  endtask

  task automatic drive_wb(input int k, input int idx, input logic [DATA_W-1:0] val,
                          input logic [DATA_W-1:0] pc, input logic ex);
    bus.wb_valid[k]                = 1'b1;
    bus.wb_idx[k*IDX_W +: IDX_W]   = IDX_W'(idx);
    bus.wb_we[k]                   = 1'($urandom_range(0, 1));
    bus.wb_rd[k*5 +: 5]            = 5'($urandom);
    bus.wb_val[k*DATA_W +: DATA_W] = val;
    bus.wb_pc[k*DATA_W +: DATA_W]  = pc;
    bus.wb_ex[k]                   = ex;
    bus.wb_store[k]                = 1'($urandom_range(0, 1));
    bus.wb_addr[k*DATA_W +: DATA_W] = $urandom;
  endtask

  task automatic tick();
    mdl_clock();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    m_reset();
    #12;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b want 10", bus.empty, bus.full); end
    checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL reset_alloc: got rdy=%b idx=%0d want 1/0", bus.alloc_ready, bus.alloc_idx); end
    checks++; if (bus.commit_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL reset_cv_flush: got %b%b want 00", bus.commit_valid, bus.flush); end
    checks++; if ({bus.commit_val, bus.commit_epc, bus.commit_addr, bus.commit_rd, bus.commit_we, bus.commit_ex, bus.commit_store} !== '0) begin
      errors++; $display("FAIL reset_payload: got val=%h epc=%h want all zero", bus.commit_val, bus.commit_epc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [DATA_W-1:0] vals [DEPTH];
    int next_c;
    int cyc;
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_valid = 1'b1;
      checks++; if (bus.alloc_idx !== IDX_W'(i) || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL fill_idx: got %0d rdy=%b want %0d rdy=1", bus.alloc_idx, bus.alloc_ready, i); end
      tick();
    end
    checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got cnt=%0d full=%b rdy=%b want 8/1/0", bus.count, bus.full, bus.alloc_ready); end
    bus.alloc_valid = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd8 || bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL fill_ninth: got cnt=%0d idx=%0d want 8/0", bus.count, bus.alloc_idx); end
    for (int j = DEPTH - 1; j >= 0; j--) begin
      vals[j] = $urandom;
      drive_wb($urandom_range(0, NUM_WB - 1), j, vals[j], $urandom, 1'b0);
      bus.commit_ready = 1'b1;
      checks++; if (bus.commit_valid !== m_cvalid()) begin errors++; $display("FAIL drain_early: got cv=%b want %b (wb idx %0d)", bus.commit_valid, m_cvalid(), j); end
      tick();
    end
    next_c = 0;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      bus.commit_ready = 1'b1;
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_val !== vals[next_c]) begin
        errors++; $display("FAIL drain_order: got cv=%b val=%h want 1 val=%h (entry %0d)", bus.commit_valid, bus.commit_val, vals[next_c], next_c); end
      next_c = (next_c + 1) % DEPTH;
      tick();
      cyc++;
    end
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL drain_end: got cnt=%0d empty=%b want 0/1", bus.count, bus.empty); end
  endtask

  task automatic test_concurrent();
    logic [DATA_W-1:0] exp_v [3];
    int base;
    exp_v = '{32'h22, 32'h33, 32'h11};
    base = m_head;
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    drive_wb(0, (base + 2) % DEPTH, 32'h11, 32'h0, 1'b0);
    drive_wb(1, base,               32'h22, 32'h0, 1'b0);
    drive_wb(2, (base + 1) % DEPTH, 32'h33, 32'h0, 1'b0);
    tick();
    for (int j = 0; j < 3; j++) begin
      bus.commit_ready = 1'b1;
      checks++; if (bus.commit_valid !== 1'b1 || bus.commit_val !== exp_v[j]) begin
        errors++; $display("FAIL concurrent_val: got cv=%b val=%h want 1 val=%h", bus.commit_valid, bus.commit_val, exp_v[j]); end
      tick();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL concurrent_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_flush();
    int base;
    base = m_head;
    for (int i = 0; i < 4; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    drive_wb(0, base,               $urandom, $urandom,    1'b0);
    drive_wb(1, (base + 1) % DEPTH, $urandom, 32'h400010,  1'b1);
    drive_wb(2, (base + 2) % DEPTH, $urandom, $urandom,    1'b0);
    tick();
    drive_wb(0, (base + 3) % DEPTH, $urandom, $urandom, 1'b0);
    bus.commit_ready = 1'b1;
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_ex !== 1'b0) begin errors++; $display("FAIL flush_first: got cv=%b ex=%b want 1/0", bus.commit_valid, bus.commit_ex); end
    tick();
    bus.commit_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    drive_wb(0, (base + 2) % DEPTH, $urandom, $urandom, 1'b0);
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_ex !== 1'b1 || bus.commit_epc !== 32'h400010) begin
      errors++; $display("FAIL flush_fault: got cv=%b ex=%b epc=%h want 1/1/00400010", bus.commit_valid, bus.commit_ex, bus.commit_epc); end
    tick();
    checks++; if (bus.flush !== 1'b1 || bus.count !== 4'd0 || bus.alloc_idx !== 3'd0) begin
      errors++; $display("FAIL flush_pulse: got flush=%b cnt=%0d idx=%0d want 1/0/0", bus.flush, bus.count, bus.alloc_idx); end
    checks++; if (bus.empty !== 1'b1 || bus.commit_valid !== 1'b0 || bus.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got empty=%b cv=%b rdy=%b want 1/0/1", bus.empty, bus.commit_valid, bus.alloc_ready); end
    bus.alloc_valid = 1'b1;
    tick();
    checks++; if (bus.flush !== 1'b0 || bus.count !== 4'd1 || bus.alloc_idx !== 3'd1) begin
      errors++; $display("FAIL flush_after: got flush=%b cnt=%0d idx=%0d want 0/1/1", bus.flush, bus.count, bus.alloc_idx); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    drive_wb(0, 0, $urandom, $urandom, 1'b0);
    tick();
    checks++; if (bus.count !== 4'd5 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL areset_pre: got cnt=%0d cv=%b want 5/1", bus.count, bus.commit_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.commit_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL areset_now: got cnt=%0d cv=%b empty=%b want 0/0/1", bus.count, bus.commit_valid, bus.empty); end
    #2;
    rst_n = 1'b1;
    m_reset();
    #1;
    checks++; if (bus.alloc_idx !== 3'd0 || bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL areset_after: got idx=%0d rdy=%b want 0/1", bus.alloc_idx, bus.alloc_ready); end
  endtask

  task automatic test_full_alloc_commit();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    for (int j = 0; j < DEPTH; j += NUM_WB) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (j + k < DEPTH) drive_wb(k, j + k, $urandom, $urandom, 1'b0);
      end
      tick();
    end
    checks++; if (bus.count !== 4'd8 || bus.commit_valid !== 1'b1) begin errors++; $display("FAIL fullac_pre: got cnt=%0d cv=%b want 8/1", bus.count, bus.commit_valid); end
    bus.alloc_valid  = 1'b1;
    bus.commit_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd7 || bus.alloc_idx !== 3'd0) begin errors++; $display("FAIL fullac_first: got cnt=%0d idx=%0d want 7/0", bus.count, bus.alloc_idx); end
    for (int c = 0; c < 5; c++) begin
      bus.alloc_valid  = 1'b1;
      bus.commit_ready = 1'b1;
      tick();
      checks++; if (bus.count !== 4'd7 || bus.alloc_idx !== IDX_W'(c + 1)) begin
        errors++; $display("FAIL fullac_steady: got cnt=%0d idx=%0d want 7/%0d", bus.count, bus.alloc_idx, c + 1); end
    end
  endtask

  task automatic test_stale_wb();
    logic [DATA_W-1:0] v;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_valid = 1'b1;
      tick();
    end
    drive_wb(0, 3, 32'hDEAD_BEEF, $urandom, 1'b0);
    tick();
    bus.alloc_valid = 1'b1;
    for (int k = 0; k < 3; k++) drive_wb(k, k, $urandom, $urandom, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      bus.commit_ready = 1'b1;
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      bus.commit_ready = 1'b1;
      checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd1) begin
        errors++; $display("FAIL stale_wait: got cv=%b cnt=%0d want 0/1", bus.commit_valid, bus.count); end
      tick();
    end
    v = $urandom;
    drive_wb(1, 3, v, $urandom, 1'b0);
    tick();
    checks++; if (bus.commit_valid !== 1'b1 || bus.commit_val !== v) begin
      errors++; $display("FAIL stale_fresh: got cv=%b val=%h want 1 val=%h", bus.commit_valid, bus.commit_val, v); end
  endtask

  task automatic test_random();
    bit [DEPTH-1:0] used;
    int idx;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      used = '0;
      bus.alloc_valid  = ($urandom_range(0, 99) < 60);
      bus.commit_ready = ($urandom_range(0, 99) < 55);
      for (int k = 0; k < NUM_WB; k++) begin
        if ($urandom_range(0, 99) < 45) begin
          if (q.size() > 0 && $urandom_range(0, 99) < 80) idx = (m_head + $urandom_range(0, q.size() - 1)) % DEPTH;
          else idx = $urandom_range(0, DEPTH - 1);
          if (!used[idx]) begin
            used[idx] = 1'b1;
            drive_wb(k, idx, $urandom, $urandom, ($urandom_range(0, 99) < 4));
          end
        end
      end
      tick();
      checks++; if (bus.count !== 4'(q.size()) || bus.alloc_idx !== IDX_W'(m_tail())) begin
        errors++; $display("FAIL rand_occ: cyc %0d got cnt=%0d idx=%0d want %0d/%0d", cyc, bus.count, bus.alloc_idx, q.size(), m_tail()); end
      checks++; if (bus.full !== (q.size() == DEPTH) || bus.empty !== (q.size() == 0) || bus.alloc_ready !== (q.size() != DEPTH)) begin
        errors++; $display("FAIL rand_flags: cyc %0d got full=%b empty=%b rdy=%b for size %0d", cyc, bus.full, bus.empty, bus.alloc_ready, q.size()); end
      checks++; if (bus.flush !== m_flush || bus.commit_valid !== m_cvalid()) begin
        errors++; $display("FAIL rand_ctl: cyc %0d got flush=%b cv=%b want %b/%b", cyc, bus.flush, bus.commit_valid, m_flush, m_cvalid()); end
      if (m_cvalid()) begin
        checks++; if (bus.commit_val !== q[0].val || bus.commit_epc !== q[0].pc || bus.commit_ex !== q[0].ex) begin
          errors++; $display("FAIL rand_head: cyc %0d got val=%h epc=%h ex=%b want %h/%h/%b", cyc, bus.commit_val, bus.commit_epc, bus.commit_ex, q[0].val, q[0].pc, q[0].ex); end
        checks++; if ({bus.commit_we, bus.commit_rd, bus.commit_store, bus.commit_addr} !== {q[0].we, q[0].rd, q[0].store, q[0].addr}) begin
          errors++; $display("FAIL rand_dest: cyc %0d got we=%b rd=%0d st=%b addr=%h want %b/%0d/%b/%h", cyc, bus.commit_we, bus.commit_rd, bus.commit_store, bus.commit_addr, q[0].we, q[0].rd, q[0].store, q[0].addr); end
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill_drain();
    test_concurrent();
    test_flush();
    test_async_reset();
    test_full_alloc_commit();
    test_stale_wb();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer for the out-of-order MIPS core.
- Allocates entries in program order at issue and accepts out-of-order results from NUM_WB writeback channels (ALU, load, slow unit, ...).
- Retires completed entries in order through a valid/ready commit handshake to the register file and store path.
- Supports precise exceptions: committing a faulting entry flushes the whole buffer.

Parameters:
- DEPTH, 8, number of entries; power of 2, minimum 2.
- IDX_W, 3, entry index width; equals log2(DEPTH).
- NUM_WB, 3, number of writeback channels.
- DATA_W, 32, width of value, address and PC fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  issue requests one entry.
- alloc_ready  out  1  buffer not full; equals !full.
- alloc_idx  out  IDX_W  index that will be allocated (tail).
- wb_valid  in  NUM_WB  per-channel result strobe.
- wb_idx  in  NUM_WB*IDX_W  target entry per channel; channel k occupies bits [k*IDX_W +: IDX_W].
- wb_we  in  NUM_WB  result writes a register.
- wb_rd  in  NUM_WB*5  destination register.
- wb_val  in  NUM_WB*DATA_W  result value.
- wb_pc  in  NUM_WB*DATA_W  instruction PC.
- wb_ex  in  NUM_WB  exception flag.
- wb_store  in  NUM_WB  entry is a store.
- wb_addr  in  NUM_WB*DATA_W  store address.
- commit_valid  out  1  head entry allocated and done.
- commit_ready  in  1  consumer accepts head.
- commit_we, commit_rd, commit_val, commit_store, commit_addr, commit_ex, commit_epc  out  1/5/DATA_W/1/DATA_W/1/DATA_W  head entry fields.
- flush  out  1  one-cycle pulse after a faulting commit.
- count  out  IDX_W+1  occupied entries.
- full, empty  out  1  count==DEPTH, count==0.

Behaviour:
- Reset (asynchronous, rst_n low):
  - head=tail=0, count=0, every busy/done bit 0, flush=0.
  - Consequently empty=1, full=0, alloc_ready=1, commit_valid=0.
  - Entry payload fields reset to 0, so all commit_* fields read 0.
- Per-entry state: busy (allocated), done (result written), plus the payload fields.
- Allocation:
  - Occurs when alloc_valid && alloc_ready at the clock edge: entry[tail] gets busy=1, done=0; tail advances with modulo-DEPTH wrap.
  - alloc_idx is combinational from tail and is valid in the same cycle as the request.
  - alloc_valid while full is ignored; no state change.
- Writeback:
  - wb_valid[k] with entry[wb_idx_k].busy=1 registers all fields and sets done=1 at the edge. Latency 1: visible on commit_* the next cycle.
  - Writeback to a non-busy entry is ignored.
  - Two channels targeting the same index in one cycle: lowest k wins. This is a protocol violation and asserts in simulation.
  - Writeback to an already-done entry overwrites it.
- Commit:
  - commit_valid = busy[head] && done[head]; all commit_* outputs are combinational from entry[head].
  - Handshake (commit_valid && commit_ready): clear busy/done of head; head advances with wrap.
- Count: +1 on allocate, -1 on commit; a simultaneous allocate and commit leaves count unchanged. A full buffer accepts no allocation, even in the same cycle as a commit.
- Exception flush:
  - A handshake with commit_ex=1 clears all busy/done bits, sets head=tail=0 and count=0, and drives flush=1 for exactly the next cycle.
  - Allocation and writebacks in the flush-triggering cycle are discarded.
  - flush is registered. In the cycle flush=1 the buffer is empty and accepts new allocations normally.
- Wrap-around: head and tail are IDX_W bits wide; full and empty are distinguished only by count.
- Writeback targeting the entry being committed in the same cycle: the commit takes priority and the writeback is dropped.
- Reset mid-operation: all in-flight entries are lost; outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Fill and drain: 8 allocations yield alloc_idx 0..7, count=8, full=1; a 9th request is ignored. Writeback entries 7→0 in reverse order; commits emerge in order 0..7, each only after its own writeback; final count=0, empty=1.
- Concurrent channels: allocate idx 0,1,2. In one cycle, ch0→idx2 val=0x11, ch1→idx0 val=0x22, ch2→idx1 val=0x33. Commits then give commit_val 0x22, 0x33, 0x11.
- Exception flush: allocate 4 entries; writeback idx1 with wb_ex=1, pc=0x400010, and all others normally. Commit idx0, then idx1 shows commit_ex=1, commit_epc=0x400010. The next cycle has flush=1, count=0, alloc_idx=0.
- Simultaneous allocate and commit at count=8, holding commit_ready=1 and alloc_valid=1: the first cycle only commits; thereafter one allocation per commit, count stays at 7.
- Async reset mid-fill: with count=5, pulse rst_n low between clock edges. Immediately count=0, commit_valid=0, empty=1; after release, alloc_idx=0.
- Stale writeback: writeback to a non-allocated idx3 followed by allocation of idx3 leaves done=0, so commit_valid stays 0 until a new writeback arrives.
